// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers one write per source, grants round-robin into a registered regfile port.
// Optional contention counter on stall_cnt is enabled by defining WB_ARB_STATS_EN.
module wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic [ADDR_W-1:0]         chk_addr1,
  input  logic [ADDR_W-1:0]         chk_addr2,
  output logic                      hazard1,
  output logic                      hazard2,
  output logic [NUM_REQ-1:0]        pending,
  output logic [31:0]               stall_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] full_q, full_d;
  logic [ADDR_W-1:0]  addr_q [NUM_REQ];
  logic [ADDR_W-1:0]  addr_d [NUM_REQ];
  logic [DATA_W-1:0]  data_q [NUM_REQ];
  logic [DATA_W-1:0]  data_d [NUM_REQ];
  logic [IDX_W-1:0]   rr_last_q, rr_last_d;
  logic               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic               hit1, hit2;

  // Round-robin search begins just after the last granted source and wraps.
  always_comb begin
    int idx;
    logic [IDX_W-1:0] cand;
    grant     = '0;
    grant_idx = rr_last_q;
    grant_vld = 1'b0;
    idx       = 0;
    cand      = '0;
    if (rdy) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx  = (int'(rr_last_q) + k) % NUM_REQ;
        cand = IDX_W'(idx);
        if (!grant_vld && full_q[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = cand;
          grant_vld   = 1'b1;
        end
      end
    end
  end

  assign req_ready = {NUM_REQ{rdy}} & (~full_q | grant);

  always_comb begin
    full_d     = full_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rr_last_d  = rr_last_q;
    rf_we_d    = rf_we_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rdy) begin
      rf_we_d = grant_vld;
      if (grant_vld) begin
        rf_waddr_d = addr_q[grant_idx];
        rf_wdata_d = data_q[grant_idx];
        rr_last_d  = grant_idx;
      end
      full_d = full_q & ~grant;
      // Writes to x0 are accepted but never occupy a buffer.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (req_addr[i*ADDR_W +: ADDR_W] != '0)) begin
          full_d[i] = 1'b1;
          addr_d[i] = req_addr[i*ADDR_W +: ADDR_W];
          data_d[i] = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q     <= '0;
      rr_last_q  <= IDX_W'(NUM_REQ - 1);
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      full_q     <= full_d;
      rr_last_q  <= rr_last_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // A read hits a pending write if it is buffered or sitting on the write port.
  always_comb begin
    hit1 = rf_we_q && (rf_waddr_q == chk_addr1);
    hit2 = rf_we_q && (rf_waddr_q == chk_addr2);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (full_q[i] && (addr_q[i] == chk_addr1)) hit1 = 1'b1;
      if (full_q[i] && (addr_q[i] == chk_addr2)) hit2 = 1'b1;
    end
  end

  assign hazard1  = hit1 && (chk_addr1 != '0);
  assign hazard2  = hit2 && (chk_addr2 != '0);
  assign pending  = full_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef WB_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rdy && |(full_q & ~grant)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: round-robin, throughput, x0 drop, hazards, freeze and async reset.
module tb_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst;
  logic                      rdy;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic [ADDR_W-1:0]         chk_addr1;
  logic [ADDR_W-1:0]         chk_addr2;
  logic                      hazard1;
  logic                      hazard2;
  logic [NUM_REQ-1:0]        pending;
  logic [31:0]               stall_cnt;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hazard1(hazard1), .hazard2(hazard2),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int src, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[src*ADDR_W +: ADDR_W] = a;
    req_data[src*DATA_W +: DATA_W] = d;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [NUM_REQ-1:0] p);
    check({tag, "_we"}, 32'(rf_we), 32'(we));
    check({tag, "_waddr"}, 32'(rf_waddr), 32'(a));
    check({tag, "_wdata"}, rf_wdata, d);
    check({tag, "_pending"}, 32'(pending), 32'(p));
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    chk_addr1 = '0; chk_addr2 = '0;
    #2;
    check_port("reset", 1'b0, 5'd0, 32'h0, 3'b000);
    check("reset_stall", stall_cnt, 32'd0);
    #10;
    rst = 1'b1;

    // Round-robin burst: rr_last starts at 2, so src0 goes first.
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
    #1;
    check("rr1_ready", 32'(req_ready), 32'h7);
    tick(); req_valid = '0;
    check_port("rr1_e0", 1'b0, 5'd0, 32'h0, 3'b111);
    tick(); check_port("rr1_e1", 1'b1, 5'd1, 32'h11, 3'b110);
    tick(); check_port("rr1_e2", 1'b1, 5'd2, 32'h22, 3'b100);
    tick(); check_port("rr1_e3", 1'b1, 5'd3, 32'h33, 3'b000);
    tick(); check_port("rr1_e4", 1'b0, 5'd3, 32'h33, 3'b000);
`ifdef WB_ARB_STATS_EN
    check("rr1_stall", stall_cnt, 32'd2);
`else
    check("rr1_stall", stall_cnt, 32'd0);
`endif

    // Second burst: src0 first again.
    req_valid = 3'b111;
    set_req(0, 5'd4, 32'h44); set_req(1, 5'd5, 32'h55); set_req(2, 5'd6, 32'h66);
    tick(); req_valid = '0;
    tick(); check_port("rr2_e1", 1'b1, 5'd4, 32'h44, 3'b110);
    tick(); check_port("rr2_e2", 1'b1, 5'd5, 32'h55, 3'b100);
    tick(); check_port("rr2_e3", 1'b1, 5'd6, 32'h66, 3'b000);
    tick(); check("rr2_idle_we", 32'(rf_we), 32'd0);

    // Single source latency.
    req_valid = 3'b001; set_req(0, 5'd5, 32'hDEADBEEF);
    tick(); req_valid = '0;
    check_port("single_e0", 1'b0, 5'd6, 32'h66, 3'b001);
    tick(); check_port("single_e1", 1'b1, 5'd5, 32'hDEADBEEF, 3'b000);
    tick(); check_port("single_e2", 1'b0, 5'd5, 32'hDEADBEEF, 3'b000);

    // Back-to-back from src1.
    req_valid = 3'b010; set_req(1, 5'd7, 32'd1);
    #1; check("b2b_ready0", 32'(req_ready[1]), 32'd1);
    tick(); set_req(1, 5'd7, 32'd2);
    #1; check("b2b_ready1", 32'(req_ready[1]), 32'd1);
    tick(); check_port("b2b_d1", 1'b1, 5'd7, 32'd1, 3'b010);
    set_req(1, 5'd7, 32'd3);
    tick(); check_port("b2b_d2", 1'b1, 5'd7, 32'd2, 3'b010);
    set_req(1, 5'd7, 32'd4);
    tick(); check_port("b2b_d3", 1'b1, 5'd7, 32'd3, 3'b010);
    req_valid = '0;
    tick(); check_port("b2b_d4", 1'b1, 5'd7, 32'd4, 3'b000);
    tick(); check("b2b_idle_we", 32'(rf_we), 32'd0);

    // Write to x0 is consumed and dropped.
    req_valid = 3'b100; set_req(2, 5'd0, 32'h1234);
    #1; check("x0_ready", 32'(req_ready[2]), 32'd1);
    tick(); req_valid = '0;
    check("x0_pending", 32'(pending), 32'd0);
    check("x0_we0", 32'(rf_we), 32'd0);
    tick(); check("x0_we1", 32'(rf_we), 32'd0);

    // Hazard tracking through buffer and write port.
    chk_addr1 = 5'd9; chk_addr2 = 5'd0;
    req_valid = 3'b010; set_req(1, 5'd10, 32'hA0);
    tick();
    req_valid = 3'b001; set_req(0, 5'd9, 32'h90);
    #1; check("haz_before", 32'(hazard1), 32'd0);
    tick(); req_valid = '0;
    check("haz_buf_we", 32'(rf_waddr), 32'd10);
    check("haz_buf", 32'(hazard1), 32'd1);
    check("haz2_buf", 32'(hazard2), 32'd0);
    tick();
    check("haz_port_waddr", 32'(rf_waddr), 32'd9);
    check("haz_port", 32'(hazard1), 32'd1);
    check("haz2_port", 32'(hazard2), 32'd0);
    tick();
    check("haz_clear", 32'(hazard1), 32'd0);

    // Freeze with two full buffers, then resume.
    req_valid = 3'b111;
    set_req(0, 5'd12, 32'hC); set_req(1, 5'd13, 32'hD); set_req(2, 5'd14, 32'hE);
    tick(); req_valid = '0;
    check("frz_load", 32'(pending), 32'h7);
    tick(); check_port("frz_pre", 1'b1, 5'd13, 32'hD, 3'b101);
    rdy = 1'b0; chk_addr1 = 5'd12;
    #1; check("frz_ready", 32'(req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_port("frz_hold", 1'b1, 5'd13, 32'hD, 3'b101);
      check("frz_haz", 32'(hazard1), 32'd1);
    end
    rdy = 1'b1;
    tick(); check_port("frz_resume", 1'b1, 5'd14, 32'hE, 3'b001);

    // Asynchronous reset mid-burst.
    #2; rst = 1'b0;
    #1;
    check_port("async_rst", 1'b0, 5'd0, 32'h0, 3'b000);
    #5; rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
